tank_unit: RTL and testbench

- Parametrised per-player tank engine for the tile-grid tank game; one instance per player.
- Each frame_tick it:
  - decodes the held keycode;
  - moves the tank one tile, subject to the wall and opponent check;
  - advances up to MAX_BUL independent bullets;
  - spawns a new bullet on a fresh fire press.
- Reads the shared tile map through a registered read port. Destroys bricks through a single-entry write port instead of copying the whole map.
- Reports opponent hits to the game-state logic.

---
 rtl/tank_unit.sv | 250 +++++++++++++++++++++++++
 tb/tb_tank_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tank_unit.sv
// Per-player tank engine: one frame update moves the tank, steps every bullet
// against the shared tile map, then spawns a bullet on a fresh fire press.
module tank_unit #(
    parameter int         MAP_W     = 20,
    parameter int         MAP_H     = 15,
    parameter int         MAX_BUL   = 4,
    parameter int         START_X   = 1,
    parameter int         START_Y   = 13,
    parameter int         START_DIR = 0,
    parameter logic [7:0] KEY_UP    = 8'h1A,
    parameter logic [7:0] KEY_LEFT  = 8'h04,
    parameter logic [7:0] KEY_DOWN  = 8'h16,
    parameter logic [7:0] KEY_RIGHT = 8'h07,
    parameter logic [7:0] KEY_FIRE  = 8'h14,
    parameter int         XW        = $clog2(MAP_W),
    parameter int         YW        = $clog2(MAP_H),
    parameter int         AW        = $clog2(MAP_W * MAP_H)
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  frame_tick,
    input  logic [7:0]            keycode,
    input  logic [XW-1:0]         opp_x,
    input  logic [YW-1:0]         opp_y,
    output logic [AW-1:0]         map_rd_addr,
    input  logic [1:0]            map_rd_data,
    output logic                  map_wr_en,
    output logic [AW-1:0]         map_wr_addr,
    output logic [1:0]            map_wr_data,
    output logic [XW-1:0]         tank_x,
    output logic [YW-1:0]         tank_y,
    output logic [1:0]            tank_dir,
    output logic [MAX_BUL-1:0]    bul_valid,
    output logic [MAX_BUL*XW-1:0] bul_x,
    output logic [MAX_BUL*YW-1:0] bul_y,
    output logic                  hit_opp,
    output logic                  busy,
    output logic                  done,
    output logic                  overrun
);

    localparam int SW = (MAX_BUL > 1) ? $clog2(MAX_BUL) : 1;
    localparam logic [XW:0]   W_LIM = (XW + 1)'(MAP_W);
    localparam logic [YW:0]   H_LIM = (YW + 1)'(MAP_H);
    localparam logic [SW-1:0] LAST  = SW'(MAX_BUL - 1);

    typedef enum logic [3:0] {
        IDLE, T_RD, T_WAIT, T_CHK, B_RD, B_WAIT, B_CHK, FIRE, DONE
    } state_t;

    state_t        state;
    logic [7:0]    key_q;
    logic          move_req;
    logic          prev_fire;
    logic [XW:0]   tgt_x;
    logic [YW:0]   tgt_y;
    logic [SW-1:0] slot;
    logic [XW-1:0] b_x   [MAX_BUL];
    logic [YW-1:0] b_y   [MAX_BUL];
    logic [1:0]    b_dir [MAX_BUL];

    logic          key_is_dir;
    logic [1:0]    key_dir;
    logic [XW:0]   kx, bnx;
    logic [YW:0]   ky, bny;
    logic          t_in, t_opp, b_in, b_opp;
    logic          free_found;
    logic [SW-1:0] free_idx;
    logic          fire_edge;

    // Positions are widened by one bit so a step off either edge lands out of range.
    function automatic logic [XW:0] step_x(input logic [XW-1:0] x, input logic [1:0] d);
        logic [XW:0] xe;
        xe = {1'b0, x};
        case (d)
            2'd1:    return xe - {{XW{1'b0}}, 1'b1};
            2'd3:    return xe + {{XW{1'b0}}, 1'b1};
            default: return xe;
        endcase
    endfunction

    function automatic logic [YW:0] step_y(input logic [YW-1:0] y, input logic [1:0] d);
        logic [YW:0] ye;
        ye = {1'b0, y};
        case (d)
            2'd0:    return ye - {{YW{1'b0}}, 1'b1};
            2'd2:    return ye + {{YW{1'b0}}, 1'b1};
            default: return ye;
        endcase
    endfunction

    function automatic logic [AW-1:0] addr_of(input logic [XW:0] x, input logic [YW:0] y);
        int a;
        a = int'(y) * MAP_W + int'(x);
        return AW'(a);
    endfunction

    always_comb begin
        key_is_dir = 1'b1;
        key_dir    = 2'd0;
        case (keycode)
            KEY_UP:    key_dir = 2'd0;
            KEY_LEFT:  key_dir = 2'd1;
            KEY_DOWN:  key_dir = 2'd2;
            KEY_RIGHT: key_dir = 2'd3;
            default:   key_is_dir = 1'b0;
        endcase
    end

    assign kx    = step_x(tank_x, key_dir);
    assign ky    = step_y(tank_y, key_dir);
    assign t_in  = (tgt_x < W_LIM) && (tgt_y < H_LIM);
    assign t_opp = (tgt_x == {1'b0, opp_x}) && (tgt_y == {1'b0, opp_y});

    assign bnx   = step_x(b_x[slot], b_dir[slot]);
    assign bny   = step_y(b_y[slot], b_dir[slot]);
    assign b_in  = (bnx < W_LIM) && (bny < H_LIM);
    assign b_opp = (bnx == {1'b0, opp_x}) && (bny == {1'b0, opp_y});

    assign fire_edge   = (key_q == KEY_FIRE) && !prev_fire;
    assign map_wr_data = 2'd0;

    // Scanning downward leaves the lowest-index free slot selected.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = MAX_BUL - 1; i >= 0; i--) begin
            if (!bul_valid[i]) begin
                free_found = 1'b1;
                free_idx   = SW'(i);
            end
        end
    end

    always_comb begin
        bul_x = '0;
        bul_y = '0;
        for (int i = 0; i < MAX_BUL; i++) begin
            bul_x[i*XW +: XW] = b_x[i];
            bul_y[i*YW +: YW] = b_y[i];
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state       <= IDLE;
            key_q       <= '0;
            move_req    <= 1'b0;
            prev_fire   <= 1'b0;
            tgt_x       <= '0;
            tgt_y       <= '0;
            slot        <= '0;
            tank_x      <= XW'(START_X);
            tank_y      <= YW'(START_Y);
            tank_dir    <= 2'(START_DIR);
            bul_valid   <= '0;
            map_rd_addr <= '0;
            map_wr_en   <= 1'b0;
            map_wr_addr <= '0;
            hit_opp     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            overrun     <= 1'b0;
            for (int i = 0; i < MAX_BUL; i++) begin
                b_x[i]   <= '0;
                b_y[i]   <= '0;
                b_dir[i] <= '0;
            end
        end else begin
            map_wr_en <= 1'b0;
            hit_opp   <= 1'b0;
            done      <= 1'b0;
            if (frame_tick && busy)
                overrun <= 1'b1;
            case (state)
                IDLE: if (frame_tick) begin
                    key_q    <= keycode;
                    busy     <= 1'b1;
                    move_req <= key_is_dir;
                    if (key_is_dir)
                        tank_dir <= key_dir;
                    tgt_x    <= kx;
                    tgt_y    <= ky;
                    state    <= T_RD;
                end
                T_RD: begin
                    if (move_req && t_in)
                        map_rd_addr <= addr_of(tgt_x, tgt_y);
                    state <= T_WAIT;
                end
                T_WAIT: state <= T_CHK;
                T_CHK: begin
                    if (move_req && t_in && map_rd_data == 2'd0 && !t_opp) begin
                        tank_x <= tgt_x[XW-1:0];
                        tank_y <= tgt_y[YW-1:0];
                    end
                    slot  <= '0;
                    state <= B_RD;
                end
                B_RD: begin
                    if (bul_valid[slot] && b_in)
                        map_rd_addr <= addr_of(bnx, bny);
                    state <= B_WAIT;
                end
                B_WAIT: state <= B_CHK;
                // The opponent test comes before the tile value so a hit is never masked.
                B_CHK: begin
                    if (bul_valid[slot]) begin
                        if (!b_in) begin
                            bul_valid[slot] <= 1'b0;
                        end else if (b_opp) begin
                            bul_valid[slot] <= 1'b0;
                            hit_opp         <= 1'b1;
                        end else if (map_rd_data == 2'd0) begin
                            b_x[slot] <= bnx[XW-1:0];
                            b_y[slot] <= bny[YW-1:0];
                        end else if (map_rd_data == 2'd2) begin
                            bul_valid[slot] <= 1'b0;
                            map_wr_en       <= 1'b1;
                            map_wr_addr     <= addr_of(bnx, bny);
                        end else begin
                            bul_valid[slot] <= 1'b0;
                        end
                    end
                    if (slot == LAST) begin
                        state <= FIRE;
                    end else begin
                        slot  <= slot + 1'b1;
                        state <= B_RD;
                    end
                end
                FIRE: begin
                    if (fire_edge && free_found) begin
                        bul_valid[free_idx] <= 1'b1;
                        b_x[free_idx]       <= tank_x;
                        b_y[free_idx]       <= tank_y;
                        b_dir[free_idx]     <= tank_dir;
                    end
                    prev_fire <= (key_q == KEY_FIRE);
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state     <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tank_unit.sv
// Directed bench for tank_unit: a small tile RAM model plus one task per scenario.
module tb_tank_unit;

    localparam logic [7:0] K_UP    = 8'h1A;
    localparam logic [7:0] K_RIGHT = 8'h07;
    localparam logic [7:0] K_FIRE  = 8'h14;
    localparam logic [7:0] K_NONE  = 8'h00;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        frame_tick = 1'b0;
    logic [7:0]  keycode = 8'h00;
    logic [4:0]  opp_x = 5'd19;
    logic [3:0]  opp_y = 4'd0;
    logic [8:0]  map_rd_addr;
    logic [1:0]  map_rd_data;
    logic        map_wr_en;
    logic [8:0]  map_wr_addr;
    logic [1:0]  map_wr_data;
    logic [4:0]  tank_x;
    logic [3:0]  tank_y;
    logic [1:0]  tank_dir;
    logic [3:0]  bul_valid;
    logic [19:0] bul_x;
    logic [15:0] bul_y;
    logic        hit_opp;
    logic        busy;
    logic        done;
    logic        overrun;

    logic [1:0]  mem [0:299];
    logic        tb_wr_en = 1'b0;
    logic [8:0]  tb_wr_addr = '0;
    logic [1:0]  tb_wr_val = '0;
    logic        tb_clr = 1'b0;

    int compared = 0;
    int mismatched = 0;
    int f_cycles, f_writes, f_hits;
    logic [8:0] f_wr_addr;
    logic [1:0] f_wr_data;

    tank_unit dut (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .keycode(keycode),
        .opp_x(opp_x), .opp_y(opp_y), .map_rd_addr(map_rd_addr), .map_rd_data(map_rd_data),
        .map_wr_en(map_wr_en), .map_wr_addr(map_wr_addr), .map_wr_data(map_wr_data),
        .tank_x(tank_x), .tank_y(tank_y), .tank_dir(tank_dir), .bul_valid(bul_valid),
        .bul_x(bul_x), .bul_y(bul_y), .hit_opp(hit_opp), .busy(busy), .done(done),
        .overrun(overrun)
    );

    always #5 Clk = ~Clk;

    // Registered-read tile RAM; the bench pokes tiles through the same port as the DUT.
    always @(posedge Clk) begin
        if (tb_clr) begin
            for (int i = 0; i < 300; i++) mem[i] <= 2'd0;
        end else begin
            if (map_wr_en && map_wr_addr < 9'd300) mem[map_wr_addr] <= map_wr_data;
            if (tb_wr_en) mem[tb_wr_addr] <= tb_wr_val;
        end
        map_rd_data <= (map_rd_addr < 9'd300) ? mem[map_rd_addr] : 2'd1;
    end

    task automatic poke(input int addr, input logic [1:0] val);
        tb_wr_addr = 9'(addr);
        tb_wr_val  = val;
        tb_wr_en   = 1'b1;
        @(posedge Clk); #1;
        tb_wr_en   = 1'b0;
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        frame_tick = 1'b0;
        keycode = K_NONE;
        opp_x = 5'd19;
        opp_y = 4'd0;
        tb_clr = 1'b1;
        @(posedge Clk); #1;
        tb_clr = 1'b0;
        @(posedge Clk); #1;
        Reset = 1'b1;
        @(posedge Clk); #1;
    endtask

    // Runs one frame: counts edges from the sampled tick to done and logs writes/hits.
    task automatic do_frame(input logic [7:0] key);
        f_cycles = 0; f_writes = 0; f_hits = 0;
        f_wr_addr = '0; f_wr_data = '0;
        keycode = key;
        frame_tick = 1'b1;
        @(posedge Clk); #1;
        frame_tick = 1'b0;
        while (f_cycles < 40) begin
            @(posedge Clk); #1;
            f_cycles++;
            if (map_wr_en) begin f_writes++; f_wr_addr = map_wr_addr; f_wr_data = map_wr_data; end
            if (hit_opp) f_hits++;
            if (done) break;
        end
        compared++;
        if (!done) begin
            mismatched++;
            $display("[TB] FAIL frame_timeout got no done after %0d cycles want done", f_cycles);
        end
        @(posedge Clk); #1;
    endtask

    task automatic face_right();
        poke(262, 2'd1);
        do_frame(K_RIGHT);
        poke(262, 2'd0);
    endtask

    task automatic test_reset();
        do_reset();
        compared++; if (tank_x !== 5'd1) begin mismatched++; $display("[TB] FAIL reset_x got %0d want 1", tank_x); end
        compared++; if (tank_y !== 4'd13) begin mismatched++; $display("[TB] FAIL reset_y got %0d want 13", tank_y); end
        compared++; if (tank_dir !== 2'd0) begin mismatched++; $display("[TB] FAIL reset_dir got %0d want 0", tank_dir); end
        compared++; if (bul_valid !== 4'b0) begin mismatched++; $display("[TB] FAIL reset_bul got %b want 0000", bul_valid); end
        compared++; if (bul_x !== 20'd0 || bul_y !== 16'd0) begin mismatched++; $display("[TB] FAIL reset_bulpos got %h/%h want 0/0", bul_x, bul_y); end
        compared++; if ({busy, done, overrun, hit_opp, map_wr_en} !== 5'b0) begin
            mismatched++; $display("[TB] FAIL reset_flags got %b want 00000", {busy, done, overrun, hit_opp, map_wr_en}); end
        compared++; if (map_rd_addr !== 9'd0) begin mismatched++; $display("[TB] FAIL reset_rdaddr got %0d want 0", map_rd_addr); end
    endtask

    task automatic test_move();
        do_reset();
        do_frame(K_RIGHT);
        compared++; if (f_cycles !== 16) begin mismatched++; $display("[TB] FAIL move_latency got %0d want 16", f_cycles); end
        compared++; if (tank_x !== 5'd2 || tank_y !== 4'd13) begin mismatched++; $display("[TB] FAIL move_pos got (%0d,%0d) want (2,13)", tank_x, tank_y); end
        compared++; if (tank_dir !== 2'd3) begin mismatched++; $display("[TB] FAIL move_dir got %0d want 3", tank_dir); end
        compared++; if (f_writes !== 0) begin mismatched++; $display("[TB] FAIL move_nowrite got %0d want 0", f_writes); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL move_busy got %b want 0", busy); end
    endtask

    task automatic test_blocked();
        do_reset();
        poke(262, 2'd1);
        do_frame(K_RIGHT);
        compared++; if (tank_x !== 5'd1 || tank_y !== 4'd13 || tank_dir !== 2'd3) begin
            mismatched++; $display("[TB] FAIL wall_block got (%0d,%0d,d%0d) want (1,13,d3)", tank_x, tank_y, tank_dir); end
        poke(262, 2'd0);
        opp_x = 5'd1; opp_y = 4'd12;
        do_frame(K_UP);
        compared++; if (tank_x !== 5'd1 || tank_y !== 4'd13 || tank_dir !== 2'd0) begin
            mismatched++; $display("[TB] FAIL opp_block got (%0d,%0d,d%0d) want (1,13,d0)", tank_x, tank_y, tank_dir); end
    endtask

    task automatic test_fire_travel();
        logic [4:0] exp_x [4];
        exp_x[0] = 5'd1; exp_x[1] = 5'd2; exp_x[2] = 5'd3; exp_x[3] = 5'd4;
        do_reset();
        face_right();
        for (int f = 0; f < 4; f++) begin
            do_frame(f < 3 ? K_FIRE : K_NONE);
            compared++; if (bul_valid !== 4'b0001) begin mismatched++; $display("[TB] FAIL travel_valid%0d got %b want 0001", f, bul_valid); end
            compared++; if (bul_x[4:0] !== exp_x[f] || bul_y[3:0] !== 4'd13) begin
                mismatched++; $display("[TB] FAIL travel_pos%0d got (%0d,%0d) want (%0d,13)", f, bul_x[4:0], bul_y[3:0], exp_x[f]); end
        end
    endtask

    task automatic test_brick();
        do_reset();
        face_right();
        poke(263, 2'd2);
        do_frame(K_FIRE);
        do_frame(K_NONE);
        compared++; if (f_writes !== 0 || bul_x[4:0] !== 5'd2) begin
            mismatched++; $display("[TB] FAIL brick_approach got writes=%0d x=%0d want 0/2", f_writes, bul_x[4:0]); end
        do_frame(K_NONE);
        compared++; if (f_writes !== 1) begin mismatched++; $display("[TB] FAIL brick_wrcount got %0d want 1", f_writes); end
        compared++; if (f_wr_addr !== 9'd263 || f_wr_data !== 2'd0) begin
            mismatched++; $display("[TB] FAIL brick_wr got addr=%0d data=%0d want 263/0", f_wr_addr, f_wr_data); end
        compared++; if (bul_valid[0] !== 1'b0) begin mismatched++; $display("[TB] FAIL brick_free got %b want 0", bul_valid[0]); end
    endtask

    task automatic test_slots();
        do_reset();
        face_right();
        for (int f = 0; f < 9; f++) do_frame((f % 2 == 0) ? K_FIRE : K_NONE);
        compared++; if (bul_valid !== 4'b1111) begin mismatched++; $display("[TB] FAIL slots_full got %b want 1111", bul_valid); end
        compared++; if (bul_x !== {5'd3, 5'd5, 5'd7, 5'd9}) begin
            mismatched++; $display("[TB] FAIL slots_pos got %h want %h", bul_x, {5'd3, 5'd5, 5'd7, 5'd9}); end
        opp_x = 5'd10; opp_y = 4'd13;
        do_frame(K_NONE);
        compared++; if (f_hits !== 1) begin mismatched++; $display("[TB] FAIL hit_pulse got %0d want 1", f_hits); end
        compared++; if (bul_valid !== 4'b1110) begin mismatched++; $display("[TB] FAIL hit_free got %b want 1110", bul_valid); end
        compared++; if (bul_x[19:5] !== {5'd4, 5'd6, 5'd8}) begin
            mismatched++; $display("[TB] FAIL hit_others got %h want %h", bul_x[19:5], {5'd4, 5'd6, 5'd8}); end
    endtask

    task automatic test_overrun_reset();
        int n;
        do_reset();
        do_frame(K_FIRE);
        keycode = K_RIGHT;
        frame_tick = 1'b1;
        @(posedge Clk); #1;
        frame_tick = 1'b0;
        repeat (4) @(posedge Clk);
        #1 frame_tick = 1'b1;
        @(posedge Clk); #1;
        frame_tick = 1'b0;
        compared++; if (overrun !== 1'b1 || busy !== 1'b1) begin
            mismatched++; $display("[TB] FAIL overrun_set got ovr=%b busy=%b want 1/1", overrun, busy); end
        n = 5;
        while (!done && n < 40) begin @(posedge Clk); #1; n++; end
        compared++; if (n !== 16) begin mismatched++; $display("[TB] FAIL overrun_latency got %0d want 16", n); end
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        compared++; if (busy !== 1'b0 || tank_x !== 5'd2) begin
            mismatched++; $display("[TB] FAIL overrun_ignored got busy=%b x=%0d want 0/2", busy, tank_x); end
        keycode = K_RIGHT;
        frame_tick = 1'b1;
        @(posedge Clk); #1;
        frame_tick = 1'b0;
        repeat (3) @(posedge Clk);
        #1 Reset = 1'b0;
        #1;
        compared++; if (tank_x !== 5'd1 || tank_y !== 4'd13) begin
            mismatched++; $display("[TB] FAIL abort_pos got (%0d,%0d) want (1,13)", tank_x, tank_y); end
        compared++; if (bul_valid !== 4'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
            mismatched++; $display("[TB] FAIL abort_flags got bul=%b busy=%b ovr=%b want 0000/0/0", bul_valid, busy, overrun); end
        @(posedge Clk); #1;
        Reset = 1'b1;
        @(posedge Clk); #1;
        do_frame(K_NONE);
        compared++; if (f_writes !== 0 || f_cycles !== 16) begin
            mismatched++; $display("[TB] FAIL abort_recover got writes=%0d cycles=%0d want 0/16", f_writes, f_cycles); end
    endtask

    initial begin
        test_reset();
        test_move();
        test_blocked();
        test_fire_travel();
        test_brick();
        test_slots();
        test_overrun_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
